// File: rtl/dpram_arbiter.sv
// dpram_arbiter
// Shares one single-port 8K x 32 RAM between two asynchronous bus ports
// (core A, core B). Each port's strobe is synchronised and edge-detected, and
// the port's request is latched. A round-robin arbiter then issues one RAM
// access at a time and returns a one-cycle acknowledge to the port that made it.

module dpram_arbiter #(
  parameter int AW          = 13,
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          a_re,
  input  logic          a_we,
  input  logic [3:0]    a_be,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  output logic          a_ack,

  input  logic          b_re,
  input  logic          b_we,
  input  logic [3:0]    b_be,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_rdata,
  output logic          b_ack,

  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,

  output logic          busy,
  output logic [1:0]    overrun
);

  // Access sequencer states.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  // Port identifiers used by the arbiter and the in-flight access record.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // ---------------------------------------------------------------------------
  // Strobe synchronisers and rising-edge detectors
  // ---------------------------------------------------------------------------
  logic                   a_strobe;
  logic                   b_strobe;
  logic [SYNC_STAGES-1:0] a_sync;
  logic [SYNC_STAGES-1:0] b_sync;
  logic                   a_edge_q;
  logic                   b_edge_q;
  logic                   a_rise;
  logic                   b_rise;

  // A read or a write strobe both open a bus cycle; the kind is resolved at latch time.
  assign a_strobe = a_re | a_we;
  assign b_strobe = b_re | b_we;

  // Shift each strobe through the synchroniser chain, then one more flop for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sync   <= '0;
      b_sync   <= '0;
      a_edge_q <= 1'b0;
      b_edge_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop in the chain sample its
      // predecessor's old value, which is what makes this a shift register.
      a_sync   <= {a_sync[SYNC_STAGES-2:0], a_strobe};
      b_sync   <= {b_sync[SYNC_STAGES-2:0], b_strobe};
      a_edge_q <= a_sync[SYNC_STAGES-1];
      b_edge_q <= b_sync[SYNC_STAGES-1];
    end
  end

  assign a_rise = a_sync[SYNC_STAGES-1] & ~a_edge_q;
  assign b_rise = b_sync[SYNC_STAGES-1] & ~b_edge_q;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [1:0] state;
  logic       last_grant;
  logic       a_pend;
  logic       b_pend;
  logic       grant_fire;
  logic       grant_port;
  logic       a_grant;
  logic       b_grant;

  // Round-robin pick: a lone requester wins; on a tie the port not served last wins.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    grant_port = PORT_A;
    if (a_pend && b_pend) begin
      grant_port = ~last_grant;
    end else if (b_pend) begin
      grant_port = PORT_B;
    end
  end

  assign grant_fire = (state == ST_IDLE) && (a_pend || b_pend);
  assign a_grant    = grant_fire && (grant_port == PORT_A);
  assign b_grant    = grant_fire && (grant_port == PORT_B);

  // ---------------------------------------------------------------------------
  // Request latching and overrun detection
  // ---------------------------------------------------------------------------
  logic          a_accept;
  logic          b_accept;
  logic [AW-1:0] a_req_addr;
  logic [AW-1:0] b_req_addr;
  logic [DW-1:0] a_req_wdata;
  logic [DW-1:0] b_req_wdata;
  logic [3:0]    a_req_be;
  logic [3:0]    b_req_be;
  logic          a_req_write;
  logic          b_req_write;

  // A new edge is taken only if the port has no request waiting, or its
  // waiting request is being granted on this very edge.
  assign a_accept = a_rise & (~a_pend | a_grant);
  assign b_accept = b_rise & (~b_pend | b_grant);

  // Track pending flags; an edge arriving on a still-pending port is flagged sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_pend  <= 1'b0;
      b_pend  <= 1'b0;
      overrun <= 2'b00;
    end else begin
      if (a_accept) begin
        a_pend <= 1'b1;
      end else if (a_grant) begin
        a_pend <= 1'b0;
      end
      if (b_accept) begin
        b_pend <= 1'b1;
      end else if (b_grant) begin
        b_pend <= 1'b0;
      end
      if (a_rise && !a_accept) begin
        overrun[0] <= 1'b1;
      end
      if (b_rise && !b_accept) begin
        overrun[1] <= 1'b1;
      end
    end
  end

  // Capture the bus payload on an accepted edge; write wins if both strobes are high.
  // NOTE: these payload registers carry no reset on purpose: they are only
  // ever consumed while the matching pend flag qualifies them.
  always_ff @(posedge clk) begin
    if (a_accept) begin
      a_req_addr  <= a_addr;
      a_req_wdata <= a_wdata;
      a_req_be    <= a_be;
      a_req_write <= a_we;
    end
    if (b_accept) begin
      b_req_addr  <= b_addr;
      b_req_wdata <= b_wdata;
      b_req_be    <= b_be;
      b_req_write <= b_we;
    end
  end

  // ---------------------------------------------------------------------------
  // Granted-request select
  // ---------------------------------------------------------------------------
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [3:0]    sel_be;
  logic          sel_write;

  // Route the winning port's latched request toward the RAM registers.
  always_comb begin
    sel_addr  = a_req_addr;
    sel_wdata = a_req_wdata;
    sel_be    = a_req_be;
    sel_write = a_req_write;
    if (grant_port == PORT_B) begin
      sel_addr  = b_req_addr;
      sel_wdata = b_req_wdata;
      sel_be    = b_req_be;
      sel_write = b_req_write;
    end
  end

  // ---------------------------------------------------------------------------
  // Access sequencer, RAM interface registers, read data and acknowledges
  // ---------------------------------------------------------------------------
  logic cur_port;
  logic cur_write;

  // IDLE grants and loads the RAM registers, ISSUE lets the RAM see the
  // access, CAPTURE returns read data and pulses the port's ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= PORT_B;
      cur_port   <= PORT_A;
      cur_write  <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 4'b0000;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      a_rdata    <= '0;
      b_rdata    <= '0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
    end else begin
      // Single-cycle pulses default low and are raised only where needed.
      ram_en <= 1'b0;
      ram_we <= 4'b0000;
      a_ack  <= 1'b0;
      b_ack  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_fire) begin
            state      <= ST_ISSUE;
            last_grant <= grant_port;
            cur_port   <= grant_port;
            cur_write  <= sel_write;
            ram_en     <= 1'b1;
            ram_addr   <= sel_addr;
            ram_wdata  <= sel_wdata;
            ram_we     <= sel_write ? sel_be : 4'b0000;
          end
        end
        ST_ISSUE: begin
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          state <= ST_IDLE;
          if (cur_port == PORT_A) begin
            a_ack <= 1'b1;
            if (!cur_write) begin
              a_rdata <= ram_rdata;
            end
          end else begin
            b_ack <= 1'b1;
            if (!cur_write) begin
              b_rdata <= ram_rdata;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE) | a_pend | b_pend;

endmodule

// File: tb/tb_dpram_arbiter.sv
// tb_dpram_arbiter
// Self-checking bench for dpram_arbiter: a behavioural RAM, a table of single
// accesses, hand sequences for timing, ties, overrun and mid-access reset,
// and a per-port queue of expected completions checked on each ack.

module tb_dpram_arbiter;

  localparam int AW          = 13;
  localparam int DW          = 32;
  localparam int SYNC_STAGES = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_re, a_we, b_re, b_we;
  logic [3:0]    a_be, b_be;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          a_ack, b_ack;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          busy;
  logic [1:0]    overrun;

  always #5 clk = ~clk;

  dpram_arbiter #(.AW(AW), .DW(DW), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst),
    .a_re(a_re), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_ack(a_ack),
    .b_re(b_re), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_ack(b_ack),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .overrun(overrun)
  );

  // Behavioural single-port RAM: byte writes, read data one cycle after ram_en.
  logic [31:0] mem [0:8191];
  always @(posedge clk) begin
    if (ram_en) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
      ram_rdata <= mem[ram_addr];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: one queue of expected completions per port.
  typedef struct {
    bit          write;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [31:0] model_a = '0;
  logic [31:0] model_b = '0;
  int          cyc = 0;
  int          a_ack_cyc = 0;
  int          b_ack_cyc = 0;

  always @(posedge clk) cyc++;

  // Ack monitor: pops the port's expectation and checks its read data register.
  always @(negedge clk) begin
    exp_t e;
    if (!ram_en) check("ram_we_idle", 32'(ram_we), 32'd0);
    if (a_ack || b_ack) check("ack_exclusive", 32'(a_ack & b_ack), 32'd0);
    if (a_ack) begin
      a_ack_cyc = cyc;
      if (q_a.size() == 0) begin
        check("a_ack_unexpected", 32'(a_ack), 32'd0);
      end else begin
        e = q_a.pop_front();
        if (e.write) begin
          check("a_rdata_hold", a_rdata, model_a);
        end else begin
          check("a_rdata", a_rdata, e.rdata);
          model_a = e.rdata;
        end
      end
    end
    if (b_ack) begin
      b_ack_cyc = cyc;
      if (q_b.size() == 0) begin
        check("b_ack_unexpected", 32'(b_ack), 32'd0);
      end else begin
        e = q_b.pop_front();
        if (e.write) begin
          check("b_rdata_hold", b_rdata, model_b);
        end else begin
          check("b_rdata", b_rdata, e.rdata);
          model_b = e.rdata;
        end
      end
    end
  end

  typedef struct {
    bit          port;
    bit          re;
    bit          we;
    logic [12:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_we;
  } vec_t;

  vec_t vecs[10];

  task automatic push_exp(input bit port, input bit write, input logic [31:0] rdata);
    exp_t e;
    e.write = write;
    e.rdata = rdata;
    if (port) q_b.push_back(e);
    else      q_a.push_back(e);
  endtask

  task automatic wait_acks(input string name);
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(q_a.size() + q_b.size()), 32'd0);
  endtask

  // One complete access on one port, with bus-side checks on the ISSUE cycle.
  task automatic run_req(input vec_t v, input string name);
    bit found = 0;
    @(negedge clk);
    if (v.port) begin
      b_re = v.re; b_we = v.we; b_addr = v.addr; b_be = v.be; b_wdata = v.wdata;
    end else begin
      a_re = v.re; a_we = v.we; a_addr = v.addr; a_be = v.be; a_wdata = v.wdata;
    end
    push_exp(v.port, v.we, v.exp_rdata);
    repeat (SYNC_STAGES + 1) @(negedge clk);
    a_re = 0; a_we = 0; b_re = 0; b_we = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (ram_en) found = 1;
      else @(negedge clk);
    end
    check({name, "_issue_seen"}, 32'(found), 32'd1);
    check({name, "_ram_addr"}, 32'(ram_addr), 32'(v.addr));
    check({name, "_ram_we"}, 32'(ram_we), 32'(v.exp_we));
    if (v.we) check({name, "_ram_wdata"}, ram_wdata, v.wdata);
    wait_acks({name, "_ack"});
    repeat (SYNC_STAGES + 1) @(negedge clk);
  endtask

  // Both ports raise a read on the same edge; expect a 3-cycle ack spacing in the given order.
  task automatic tie(input string name, input bit a_first);
    int diff;
    @(negedge clk);
    a_re = 1; a_addr = 13'h0001;
    b_re = 1; b_addr = 13'h0002;
    push_exp(0, 0, 32'hA1A1_0001);
    push_exp(1, 0, 32'hB2B2_0002);
    repeat (SYNC_STAGES + 1) @(negedge clk);
    a_re = 0; b_re = 0;
    wait_acks({name, "_acks"});
    diff = a_first ? (b_ack_cyc - a_ack_cyc) : (a_ack_cyc - b_ack_cyc);
    check({name, "_order"}, 32'(diff), 32'd3);
    repeat (SYNC_STAGES + 1) @(negedge clk);
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1;
    q_a.delete();
    q_b.delete();
    model_a = '0;
    model_b = '0;
    repeat (cycles) @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    vec_t v;

    for (int i = 0; i < 8192; i++) mem[i] = '0;
    mem[13'h0001] = 32'hA1A1_0001;
    mem[13'h0002] = 32'hB2B2_0002;
    mem[13'h0003] = 32'hC3C3_0003;
    mem[13'h0010] = 32'hDEAD_BEEF;
    mem[13'h0200] = 32'h1234_5678;

    //         port re  we  addr      be       wdata         exp_rdata     exp_we
    vecs[0] = '{0, 1, 0, 13'h0010, 4'b0000, 32'h0,        32'hDEAD_BEEF, 4'b0000};
    vecs[1] = '{1, 0, 1, 13'h1FFF, 4'b0101, 32'h1122_3344, 32'h0,        4'b0101};
    vecs[2] = '{1, 1, 0, 13'h1FFF, 4'b0000, 32'h0,        32'h0022_0044, 4'b0000};
    vecs[3] = '{0, 0, 1, 13'h0100, 4'b1111, 32'hCAFE_F00D, 32'h0,        4'b1111};
    vecs[4] = '{0, 1, 0, 13'h0100, 4'b0000, 32'h0,        32'hCAFE_F00D, 4'b0000};
    vecs[5] = '{1, 0, 1, 13'h0200, 4'b1000, 32'hAABB_CCDD, 32'h0,        4'b1000};
    vecs[6] = '{1, 1, 0, 13'h0200, 4'b0000, 32'h0,        32'hAA34_5678, 4'b0000};
    vecs[7] = '{0, 1, 1, 13'h0300, 4'b0011, 32'h5555_AAAA, 32'h0,        4'b0011};
    vecs[8] = '{0, 1, 0, 13'h0300, 4'b0000, 32'h0,        32'h0000_AAAA, 4'b0000};
    vecs[9] = '{0, 1, 0, 13'h0000, 4'b0000, 32'h0,        32'h0000_0000, 4'b0000};

    a_re = 0; a_we = 0; a_be = 0; a_addr = 0; a_wdata = 0;
    b_re = 0; b_we = 0; b_be = 0; b_addr = 0; b_wdata = 0;

    // Reset values, checked while reset is still held.
    rst = 1;
    repeat (3) @(negedge clk);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_a_rdata", a_rdata, 32'd0);
    check("rst_b_rdata", b_rdata, 32'd0);
    check("rst_acks", 32'({a_ack, b_ack}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst = 0;
    repeat (2) @(negedge clk);

    // Edge-exact timing of a port A read (E1 = first edge sampling the strobe).
    @(negedge clk);
    a_re = 1; a_addr = 13'h0010;
    push_exp(0, 0, 32'hDEAD_BEEF);
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      #1;
      if (e == 3) begin
        a_re = 0;
        check("t_e3_busy", 32'(busy), 32'd1);
        check("t_e3_ram_en", 32'(ram_en), 32'd0);
      end
      if (e == 4) begin
        check("t_e4_ram_en", 32'(ram_en), 32'd1);
        check("t_e4_ram_addr", 32'(ram_addr), 32'h0010);
        check("t_e4_ram_we", 32'(ram_we), 32'd0);
      end
      if (e == 5) begin
        check("t_e5_ram_en", 32'(ram_en), 32'd0);
        check("t_e5_a_ack", 32'(a_ack), 32'd0);
      end
      if (e == 6) check("t_e6_a_ack", 32'(a_ack), 32'd1);
      if (e == 7) begin
        check("t_e7_a_ack", 32'(a_ack), 32'd0);
        check("t_e7_a_rdata", a_rdata, 32'hDEAD_BEEF);
      end
    end
    repeat (4) @(negedge clk);
    check("t_a_rdata_held", a_rdata, 32'hDEAD_BEEF);
    check("t_b_rdata_untouched", b_rdata, 32'd0);

    // Table of single accesses, including byte writes and write-over-read priority.
    for (int i = 0; i < 10; i++) run_req(vecs[i], $sformatf("vec%0d", i));
    check("b_rdata_after_byte_write", b_rdata, 32'hAA34_5678);

    // Ties from a clean reset: A first, then after a lone A access, B first.
    apply_reset(2);
    repeat (2) @(negedge clk);
    tie("tie1", 1);
    v = '{0, 1, 0, 13'h0003, 4'b0000, 32'h0, 32'hC3C3_0003, 4'b0000};
    run_req(v, "tie_between");
    tie("tie2", 0);

    // Overrun: B strobes twice while its first request waits behind A's access.
    check("ovr_before", 32'(overrun), 32'd0);
    @(negedge clk);
    a_re = 1; a_addr = 13'h0010;
    b_addr = 13'h0002;
    push_exp(0, 0, 32'hDEAD_BEEF);
    @(negedge clk);
    b_re = 1;
    push_exp(1, 0, 32'hB2B2_0002);
    @(negedge clk);
    b_re = 0;
    @(negedge clk);
    b_re = 1;
    a_re = 0;
    @(negedge clk);
    b_re = 0;
    b_addr = 13'h0003;
    wait_acks("ovr_acks");
    repeat (10) @(negedge clk);
    check("ovr_set", 32'(overrun), 32'b10);
    check("ovr_b_rdata", b_rdata, 32'hB2B2_0002);
    v = '{1, 1, 0, 13'h1FFF, 4'b0000, 32'h0, 32'h0022_0044, 4'b0000};
    run_req(v, "ovr_after");
    check("ovr_sticky", 32'(overrun), 32'b10);

    // Reset while the access is in ISSUE: no ack, everything back to idle.
    @(negedge clk);
    a_re = 1; a_addr = 13'h0010;
    repeat (SYNC_STAGES + 1) @(negedge clk);
    a_re = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (ram_en) found = 1;
      else @(negedge clk);
    end
    check("mid_rst_issue_seen", 32'(found), 32'd1);
    apply_reset(1);
    check("mid_rst_ram_en", 32'(ram_en), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    check("mid_rst_a_ack", 32'(a_ack), 32'd0);
    check("mid_rst_a_rdata", a_rdata, 32'd0);
    repeat (8) @(negedge clk);
    check("mid_rst_still_idle", 32'(busy), 32'd0);
    run_req(vecs[0], "post_rst");

    check("final_q_a", 32'(q_a.size()), 32'd0);
    check("final_q_b", 32'(q_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
